// File: rtl/bcm_inv.sv
// bcm_inv: enumerates every 3-bit input that the bcm map sends to a given 2-bit code, ascending, over valid/ready
module bcm_inv #(
  parameter logic [15:0] MAP = 16'h0F37
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_code,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_data,
  output logic       rsp_last,
  output logic       rsp_none,
  output logic [3:0] rsp_count
);
  typedef enum logic {IDLE, EMIT} state_e;
  state_e     state_q, state_d;
  logic [7:0] mask_q, mask_d, match;
  logic [3:0] count_q, count_d, pop;
  logic [2:0] low;
  logic       emit, last;
  // descending scan so the lowest set index of the mask wins
  always_comb begin
    match = '0;
    pop = '0;
    low = '0;
    for (int k = 7; k >= 0; k--) begin
      match[k] = MAP[2*k +: 2] == req_code;
      pop = pop + 4'(match[k]);
      if (mask_q[k]) low = 3'(k);
    end
  end
  assign emit = state_q == EMIT;
  assign last = (mask_q & (mask_q - 8'd1)) == 8'd0;
  assign req_ready = !emit;
  assign rsp_valid = emit;
  assign rsp_data = low;
  assign rsp_last = emit && last;
  assign rsp_none = emit && mask_q == 8'd0;
  assign rsp_count = count_q;
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    count_d = count_q;
    if (!emit && req_valid) begin
      state_d = EMIT;
      mask_d = match;
      count_d = pop;
    end else if (emit && rsp_ready) begin
      mask_d = mask_q & (mask_q - 8'd1);
      state_d = last ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      mask_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      count_q <= count_d;
    end
  end
endmodule

// File: doc/bcm_inv.md
Name: bcm_inv

Overview:
- Inverse-lookup companion of the 3-to-2 bcm code mapping: takes a 2-bit output code and enumerates every 3-bit input that maps to it.
- Candidates are emitted in ascending order over a valid/ready response stream.
- Used by self-checking benches and by control logic that needs the preimage set of a bcm code.
- Single clock domain; request side and response side each use a valid/ready handshake.

Parameters:
- MAP, 16'h0F37, forward table; bits [2k+1:2k] hold the bcm output for input k. The default encodes 0→11, 1→01, 2→11, 3→00, 4→11, 5→11, 6→00, 7→00.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_code  input  2  code whose preimages are wanted
- rsp_valid  output  1  response word valid
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  3  preimage value (input k)
- rsp_last  output  1  final word of the current request
- rsp_none  output  1  request code has no preimage
- rsp_count  output  4  number of preimages for the current request (0..8)

Behaviour:
- Reset (rst_b=0 at a clk edge) overrides everything:
  - state←IDLE, match mask←0
  - req_ready=1 after reset
  - rsp_valid=0, rsp_data=0, rsp_last=0, rsp_none=0, rsp_count=0
  - Reset in the middle of a burst discards the remaining words.
- States: IDLE, EMIT.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid && req_ready at edge T, register:
    - mask[k] = (MAP[2k+1:2k] == req_code) for k=0..7
    - rsp_count = popcount(mask)
  - Go to EMIT. rsp_valid=1 from cycle T+1 (latency 1).
- EMIT:
  - req_ready=0; req_valid is ignored and the request is not consumed.
  - rsp_data = index of the lowest set bit of mask.
  - rsp_last = 1 when mask has exactly one bit set.
  - Mask=0 (no preimage): one word with rsp_data=0, rsp_none=1, rsp_last=1.
  - On rsp_valid && rsp_ready: clear the emitted bit.
    - If rsp_last was 1: go to IDLE. req_ready=1 in the next cycle; rsp_valid=0 that cycle, with no back-to-back overlap.
    - Otherwise present the next-lowest index in the next cycle.
  - While rsp_ready=0: rsp_data, rsp_last, rsp_none and rsp_count stay stable.
- rsp_count:
  - Holds its value from acceptance through the last handshake.
  - Holds in IDLE until the next acceptance.
- Ordering: strictly ascending k; each matching k is emitted exactly once.
- Simultaneous events: a req_valid in the same cycle as the last response handshake is not accepted; acceptance occurs at the earliest on the following edge.
- Throughput: one word per cycle with rsp_ready held high.
- The block has no internal buffering beyond the 8-bit mask.

Test Plan:
- Reset hold 2 cycles then release → req_ready=1, rsp_valid=0, rsp_count=0.
- req_code=2'b11, rsp_ready=1 → rsp_count=4; words 0,2,4,5 on consecutive cycles starting T+1; rsp_last only on 5; req_ready=1 one cycle after.
- req_code=2'b01 → single word rsp_data=1, rsp_last=1, rsp_none=0, rsp_count=1. req_code=2'b00 → words 3,6,7 with last on 7, rsp_count=3.
- req_code=2'b10 → one word rsp_none=1, rsp_data=0, rsp_last=1, rsp_count=0, then IDLE.
- Backpressure: req_code=2'b11 with rsp_ready toggling 0,0,1,0,1,1,0,1 → each word held stable while stalled; sequence 0,2,4,5 unchanged. A req_valid pulsed during EMIT is not accepted.
- Reset mid-burst: req_code=2'b11, drop rst_b after word 2 is accepted → next cycle rsp_valid=0 and req_ready=1. A new request with code 01 then yields only word 1.
